adc_req_arbiter: RTL and testbench
==================================

Name: adc_req_arbiter

Overview:
- Shares the single serial ADC conversion engine (12-bit, 8-channel, one conversion per command) between several on-chip requesters, e.g. the line follower, battery monitor and obstacle sensor.
- Grants requests round-robin, issues one conversion command at a time, and returns the result to the granted requester.
- Applies a watchdog timeout so a stalled conversion cannot lock up the arbiter.
- Sits between the sensor-consuming logic and the ADC SPI engine.

Parameters:
- NREQ, 3: number of requesters (2..8).
- CHAN_W, 3: ADC channel index width.
- DATA_W, 12: conversion result width.
- TIMEOUT, 400: maximum clk cycles in WAIT before abort. One conversion frame is about 120 clk at 12 MHz / 6 SCLK.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request, held until accepted.
- req_chan  in  NREQ*CHAN_W  requester i's channel in bits [i*CHAN_W +: CHAN_W].
- req_ready  out  NREQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NREQ  one-cycle result pulse to the owning requester, one-hot.
- rsp_data  out  DATA_W  result, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- adc_start  out  1  one-cycle conversion command.
- adc_chan  out  CHAN_W  channel for adc_start, held stable through WAIT.
- adc_busy  in  1  engine busy; a start is legal only when low.
- adc_done  in  1  one-cycle result-ready strobe.
- adc_data  in  DATA_W  result, valid with adc_done.

Behaviour:
- Reset values (async on rst high): all outputs 0, state IDLE, grant pointer = NREQ-1 (requester 0 has first priority), timeout counter 0. Reset mid-conversion abandons the transaction with no rsp_valid; a late adc_done after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - In the same cycle: req_ready[sel]=1; latch sel and its req_chan; pointer<=sel; go to ISSUE.
  - No req_valid: stay in IDLE.
  - req_chan is sampled only in the accept cycle.
  - A requester may drop req_valid before it is accepted, with no side effect.
- ISSUE:
  - adc_busy=0: pulse adc_start for one cycle, drive adc_chan = latched channel, clear the counter, go to WAIT.
  - adc_busy=1: hold in ISSUE. No timeout applies here.
- WAIT:
  - The counter increments every cycle.
  - adc_done=1: latch adc_data, rsp_err<=0, go to RESP.
  - Else, counter reaching TIMEOUT-1: latch data 0, rsp_err<=1, go to RESP.
  - If adc_done and the timeout fall in the same cycle, adc_done wins.
- RESP: rsp_valid[sel]=1 for exactly one cycle with rsp_data and rsp_err, then go to IDLE.
- adc_done outside WAIT is ignored.
- Latency, with accept at cycle T and adc_busy low:
  - adc_start at T+1.
  - With adc_done at cycle D, rsp_valid at D+1.
  - Next accept no earlier than D+2.
- Fairness: a continuously asserted requester is served at most once per NREQ grants when others are waiting.
- At most one transaction is outstanding. rsp_data/rsp_err hold their value between responses.

Decomposition:
- Shared package adc_pkg: CHAN_W, DATA_W, FSM state encoding (2-bit, localparam), TIMEOUT default, channel constants (line sensors L/C/R, battery).
- One sub-module, rr_arbiter: NREQ-bit request vector plus pointer in, one-hot grant plus index out, purely combinational. The pointer register stays in adc_req_arbiter.

Test Plan:
- Single request: req_valid=001, chan0=5; engine model returns 0xA5C 120 cycles after start → req_ready=001 at T, adc_start with adc_chan=5 at T+1, rsp_valid=001 with rsp_data=0xA5C, rsp_err=0 one cycle after adc_done.
- Round-robin: all three requesters held valid continuously → grant order 0,1,2,0,1,2; each rsp_valid bit matches its grant and its own channel.
- Busy hold: adc_busy=1 for 50 cycles after accept → adc_start stays 0 for those 50 cycles and pulses on the first cycle busy is low; no error.
- Timeout: model never asserts adc_done → rsp_valid pulse exactly TIMEOUT cycles after adc_start, rsp_err=1, rsp_data=0; the next request proceeds normally.
- Collision and stray done: adc_done on the same cycle the counter hits TIMEOUT-1 → rsp_err=0 with the data. A stray adc_done in IDLE → no rsp_valid.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT → all outputs 0 immediately; the subsequent adc_done produces no response; the next grant goes to requester 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC request arbiter.
package adc_pkg;

  localparam int unsigned ADC_CHAN_W  = 3;
  localparam int unsigned ADC_DATA_W  = 12;
  localparam int unsigned ADC_TIMEOUT = 400;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Board wiring of the ADC inputs
  localparam logic [ADC_CHAN_W-1:0] CH_LINE_L = 3'd0;
  localparam logic [ADC_CHAN_W-1:0] CH_LINE_C = 3'd1;
  localparam logic [ADC_CHAN_W-1:0] CH_LINE_R = 3'd2;
  localparam logic [ADC_CHAN_W-1:0] CH_BATT   = 3'd7;

endpackage

// File: rtl/adc_req_arbiter_if.sv
// Requester-side and ADC-engine-side signals of the arbiter, bundled with two views.
interface adc_req_arbiter_if
  import adc_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned CHAN_W = ADC_CHAN_W,
  parameter int unsigned DATA_W = ADC_DATA_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*CHAN_W-1:0] req_chan;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;
  logic                   adc_start;
  logic [CHAN_W-1:0]      adc_chan;
  logic                   adc_busy;
  logic                   adc_done;
  logic [DATA_W-1:0]      adc_data;

  modport slave (
    input  req_valid, req_chan, adc_busy, adc_done, adc_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_chan
  );

  modport master (
    output req_valid, req_chan, adc_busy, adc_done, adc_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_chan
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/adc_req_arbiter.sv
// Shares one ADC conversion engine among NREQ requesters, round-robin, with a WAIT watchdog.
module adc_req_arbiter
  import adc_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned CHAN_W  = ADC_CHAN_W,
  parameter int unsigned DATA_W  = ADC_DATA_W,
  parameter int unsigned TIMEOUT = ADC_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  adc_req_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  sel_q;
  logic [CHAN_W-1:0] chan_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [NREQ-1:0]   sel_oh;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign sel_oh  = NREQ'(1) << sel_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // The watchdog fires on the cycle the counter's next value reaches TIMEOUT-1, which places
  // the error response exactly TIMEOUT cycles after adc_start.
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IDX_W'(NREQ - 1);
      sel_q       <= '0;
      chan_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            sel_q   <= gnt_idx;
            ptr_q   <= gnt_idx;
            chan_q  <= bus.req_chan[gnt_idx*CHAN_W +: CHAN_W];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!bus.adc_busy) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_inc;
          if (bus.adc_done) begin
            rsp_data_q  <= bus.adc_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= sel_oh;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= sel_oh;
            state_q     <= StResp;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle) ? gnt : '0;
  assign bus.adc_start = (state_q == StIssue) && !bus.adc_busy;
  assign bus.adc_chan  = chan_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Directed bench for adc_req_arbiter with a response scoreboard keyed on expected cycle.
module tb_adc_req_arbiter;
  import adc_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned CW   = 3;
  localparam int unsigned DW   = 12;
  localparam int unsigned TMO  = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_req_arbiter_if #(.NREQ(NREQ), .CHAN_W(CW), .DATA_W(DW)) bus ();

  adc_req_arbiter #(
    .NREQ    (NREQ),
    .CHAN_W  (CW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [NREQ-1:0] last_ready;
  logic [NREQ-1:0] last_rsp;
  logic            last_start;
  logic [CW-1:0]   last_chan;
  int              last_cyc;

  function automatic logic [NREQ-1:0] oh(int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Observe the current cycle (posedge+3), score any response, then advance one clock.
  task automatic step();
    exp_t e;
    #2;
    last_ready = bus.req_ready;
    last_start = bus.adc_start;
    last_chan  = bus.adc_chan;
    last_rsp   = bus.rsp_valid;
    last_cyc   = cyc;
    if (bus.rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("stray_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh(e.idx)));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_start"}, 32'(bus.adc_start), 32'd0);
    chk({tag, "_chan"}, 32'(bus.adc_chan), 32'd0);
  endtask

  task automatic wait_ready(int idx, output int t);
    int k = 0;
    do begin step(); k++; end while (last_ready === '0 && k < 20);
    chk("req_ready", 32'(last_ready), 32'(oh(idx)));
    t = last_cyc;
  endtask

  task automatic wait_start(int exp_cyc, logic [CW-1:0] chan, output int s);
    int k = 0;
    do begin step(); k++; end while (!last_start && k < 10);
    chk("start_cyc", 32'(last_cyc), 32'(exp_cyc));
    chk("adc_chan", 32'(last_chan), 32'(chan));
    s = last_cyc;
  endtask

  // One full transaction; done_dly < 0 means the engine never answers.
  task automatic serve(int idx, logic [CW-1:0] chan, bit keep, int busy_n, int done_dly,
                       logic [DW-1:0] data);
    int t, s, k;
    int busy_starts = 0;
    bus.req_valid[idx]          = 1'b1;
    bus.req_chan[idx*CW +: CW] = chan;
    wait_ready(idx, t);
    if (!keep) bus.req_valid[idx] = 1'b0;
    if (busy_n > 0) begin
      bus.adc_busy = 1'b1;
      for (int i = 0; i < busy_n; i++) begin
        step();
        busy_starts += int'(last_start);
      end
      chk("start_while_busy", 32'(busy_starts), 32'd0);
      bus.adc_busy = 1'b0;
    end
    wait_start(t + 1 + busy_n, chan, s);
    if (done_dly >= 0) begin
      for (int i = 1; i < done_dly; i++) step();
      bus.adc_done = 1'b1;
      bus.adc_data = data;
      exp_q.push_back('{idx: idx, data: data, err: 1'b0, cyc: s + done_dly + 1});
      step();
      bus.adc_done = 1'b0;
      bus.adc_data = '0;
    end else begin
      exp_q.push_back('{idx: idx, data: '0, err: 1'b1, cyc: s + int'(TMO)});
    end
    k = 0;
    while (exp_q.size() != 0 && k < int'(TMO) + 20) begin step(); k++; end
    chk("rsp_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int t, s;
    logic [NREQ-1:0] seen;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_chan  = '0;
    bus.adc_busy  = 1'b0;
    bus.adc_done  = 1'b0;
    bus.adc_data  = '0;
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    step();

    // Single request, 120-cycle conversion
    serve(0, 3'd5, 1'b0, 0, 120, 12'hA5C);
    // Engine busy for 50 cycles after accept
    serve(1, 3'd2, 1'b0, 50, 40, 12'h5A5);
    // Engine never answers, then a normal transaction
    serve(2, 3'd7, 1'b0, 0, -1, '0);
    serve(0, 3'd3, 1'b0, 0, 30, 12'h123);
    // adc_done on the same cycle as the watchdog
    serve(1, 3'd4, 1'b0, 0, int'(TMO) - 1, 12'h3C3);

    // Stray adc_done while idle
    bus.adc_done = 1'b1;
    bus.adc_data = 12'hEEE;
    step();
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    seen = '0;
    for (int i = 0; i < 8; i++) begin step(); seen |= last_rsp; end
    chk("stray_done_rsp", 32'(seen), 32'd0);
    chk("rsp_data_hold", 32'(bus.rsp_data), 32'h3C3);
    chk("rsp_err_hold", 32'(bus.rsp_err), 32'd0);

    // Reset in the middle of WAIT
    bus.req_valid[2]      = 1'b1;
    bus.req_chan[2*CW +: CW] = 3'd6;
    wait_ready(2, t);
    bus.req_valid[2] = 1'b0;
    wait_start(t + 1, 3'd6, s);
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid_wait");
    step();
    rst          = 1'b0;
    bus.adc_done = 1'b1;
    bus.adc_data = 12'hFFF;
    step();
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    seen = '0;
    for (int i = 0; i < 6; i++) begin step(); seen |= last_rsp; end
    chk("late_done_rsp", 32'(seen), 32'd0);
    bus.req_valid = '1;
    serve(0, 3'd1, 1'b0, 0, 15, 12'h0AB);
    bus.req_valid = '0;

    // Round-robin with all requesters held continuously
    do_reset();
    bus.req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      serve(i % 3, CW'(i % 3 + 1), 1'b1, 0, 10 + i, DW'(12'h100 + i * 12'h11));
    end
    bus.req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
